bp_mmio_req_arbiter: RTL and testbench

- Shares the single BedRock I/O command/response port of the manycore MMIO bridge between num_req_p BlackParrot requesters (e.g. per-core uncached I/O paths).
- Arbitrates commands round-robin and records the source requester of each issued command.
- The bridge returns responses strictly in command order, so each response is routed back to the recorded requester.
- Caps outstanding commands at max_outstanding_p, which matches the bridge's own outstanding limit.

---
 rtl/bp_mmio_req_arbiter_pkg.sv | 14 +
 rtl/bp_mmio_req_arbiter_rr.sv | 39 +++
 rtl/bp_mmio_req_arbiter.sv | 117 +++++++++++
 tb/tb_bp_mmio_req_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bp_mmio_req_arbiter_pkg.sv
// Shared helpers for the MMIO request arbiter: width math matching the
// bsg safe-clog2 / width macros so the arbiter stays self-contained.
package bp_mmio_req_arbiter_pkg;

    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Bits needed to hold the value n itself (0..n inclusive).
    function automatic int width_of(input int n);
        return (n <= 0) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bp_mmio_req_arbiter_rr.sv
// Round-robin grant generator; the priority pointer lives here and moves
// past the winner only when the grant is actually consumed.
module bp_mmio_req_arbiter_rr #(
    parameter int num_req_p = 2,
    parameter int lg_req_lp = 1
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic [num_req_p-1:0] reqs_i,
    input  logic                 yumi_i,
    output logic [lg_req_lp-1:0] grant_id_o,
    output logic                 v_o
);

    logic [lg_req_lp-1:0] ptr_r;

    always_comb begin
        int idx;
        idx        = 0;
        grant_id_o = '0;
        v_o        = 1'b0;
        for (int k = 0; k < num_req_p; k++) begin
            idx = int'(ptr_r) + k;
            if (idx >= num_req_p) idx = idx - num_req_p;
            if (!v_o && reqs_i[idx]) begin
                v_o        = 1'b1;
                grant_id_o = lg_req_lp'(idx);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i)
            ptr_r <= '0;
        else if (yumi_i)
            ptr_r <= (grant_id_o == lg_req_lp'(num_req_p - 1)) ? '0 : grant_id_o + 1'b1;
    end

endmodule

// File: rtl/bp_mmio_req_arbiter.sv
// Shares one BedRock I/O command/response port among num_req_p requesters;
// in-order responses are steered back using a FIFO of issuing requester IDs.
module bp_mmio_req_arbiter
    import bp_mmio_req_arbiter_pkg::*;
#(
    parameter int num_req_p         = 2,
    parameter int msg_width_p       = 576,
    parameter int max_outstanding_p = 4,
    localparam int lg_req_lp        = safe_clog2(num_req_p)
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,

    input  logic [num_req_p*msg_width_p-1:0] req_cmd_i,
    input  logic [num_req_p-1:0]           req_cmd_v_i,
    output logic [num_req_p-1:0]           req_cmd_ready_and_o,

    output logic [msg_width_p-1:0]         io_cmd_o,
    output logic                           io_cmd_v_o,
    input  logic                           io_cmd_ready_and_i,

    input  logic [msg_width_p-1:0]         io_resp_i,
    input  logic                           io_resp_v_i,
    output logic                           io_resp_yumi_o,

    output logic [msg_width_p-1:0]         req_resp_o,
    output logic [num_req_p-1:0]           req_resp_v_o,
    input  logic [num_req_p-1:0]           req_resp_yumi_i
);

    localparam int cnt_w_lp   = width_of(max_outstanding_p);
    localparam int lg_els_lp  = safe_clog2(max_outstanding_p);

    logic [num_req_p-1:0][msg_width_p-1:0] cmd_slots;
    logic [lg_req_lp-1:0] grant_id;
    logic                 arb_v;
    logic                 issue_ok;
    logic                 cmd_xfer;
    logic                 resp_pop;

    // ID FIFO: occupancy doubles as the outstanding-command count
    logic [lg_req_lp-1:0] id_mem [max_outstanding_p];
    logic [lg_els_lp-1:0] rptr_r, wptr_r;
    logic [cnt_w_lp-1:0]  count_r;
    logic                 fifo_v;
    logic [lg_req_lp-1:0] head_id;

    function automatic logic [lg_els_lp-1:0] ptr_inc(input logic [lg_els_lp-1:0] p);
        return (p == lg_els_lp'(max_outstanding_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign cmd_slots = req_cmd_i;

    bp_mmio_req_arbiter_rr #(
        .num_req_p (num_req_p),
        .lg_req_lp (lg_req_lp)
    ) u_rr (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .reqs_i     (req_cmd_v_i),
        .yumi_i     (cmd_xfer),
        .grant_id_o (grant_id),
        .v_o        (arb_v)
    );

    // No bypass: a retire in this cycle never frees a slot for this cycle
    assign issue_ok   = reset_n_i & (count_r < cnt_w_lp'(max_outstanding_p));
    assign io_cmd_v_o = issue_ok & arb_v;
    assign io_cmd_o   = cmd_slots[grant_id];
    assign cmd_xfer   = io_cmd_v_o & io_cmd_ready_and_i;

    always_comb begin
        req_cmd_ready_and_o = '0;
        if (io_cmd_v_o) req_cmd_ready_and_o[grant_id] = io_cmd_ready_and_i;
    end

    assign fifo_v     = (count_r != '0);
    assign head_id    = id_mem[rptr_r];
    assign req_resp_o = io_resp_i;

    always_comb begin
        req_resp_v_o = '0;
        if (reset_n_i && io_resp_v_i && fifo_v) req_resp_v_o[head_id] = 1'b1;
    end

    assign resp_pop       = req_resp_v_o[head_id] & req_resp_yumi_i[head_id];
    assign io_resp_yumi_o = resp_pop;

    always_ff @(posedge clk_i) begin
        if (cmd_xfer) id_mem[wptr_r] <= grant_id;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rptr_r  <= '0;
            wptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (cmd_xfer) wptr_r <= ptr_inc(wptr_r);
            if (resp_pop) rptr_r <= ptr_inc(rptr_r);
            case ({cmd_xfer, resp_pop})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

`ifndef SYNTHESIS
    assert property (@(posedge clk_i) disable iff (!reset_n_i) io_resp_v_i |-> fifo_v)
        else $error("bp_mmio_req_arbiter: response arrived with nothing outstanding");
    assert property (@(posedge clk_i) disable iff (!reset_n_i)
                     (req_resp_yumi_i & ~req_resp_v_o) == '0)
        else $error("bp_mmio_req_arbiter: yumi from a requester not owning the response");
`endif

endmodule

// File: tb/tb_bp_mmio_req_arbiter.sv
// Randomized scoreboard bench: a driver models requesters and an in-order
// bridge; a monitor checks every cycle against a queue-based reference.
module tb_bp_mmio_req_arbiter;

    localparam int N    = 2;
    localparam int W    = 64;
    localparam int MAXO = 4;
    localparam logic [W-1:0] KEY = 64'hA5A5_5A5A_0F0F_F0F0;

    logic             clk_i = 1'b0;
    logic             reset_n_i;
    logic [N*W-1:0]   req_cmd_i;
    logic [N-1:0]     req_cmd_v_i;
    logic [N-1:0]     req_cmd_ready_and_o;
    logic [W-1:0]     io_cmd_o;
    logic             io_cmd_v_o;
    logic             io_cmd_ready_and_i;
    logic [W-1:0]     io_resp_i;
    logic             io_resp_v_i;
    logic             io_resp_yumi_o;
    logic [W-1:0]     req_resp_o;
    logic [N-1:0]     req_resp_v_o;
    logic [N-1:0]     req_resp_yumi_i;

    logic [N-1:0][W-1:0] cur_cmd;
    logic [N-1:0]        yumi_en;

    assign req_cmd_i       = cur_cmd;
    assign req_resp_yumi_i = req_resp_v_o & yumi_en;

    always #5 clk_i = ~clk_i;

    bp_mmio_req_arbiter #(
        .num_req_p         (N),
        .msg_width_p       (W),
        .max_outstanding_p (MAXO)
    ) dut (
        .clk_i               (clk_i),
        .reset_n_i           (reset_n_i),
        .req_cmd_i           (req_cmd_i),
        .req_cmd_v_i         (req_cmd_v_i),
        .req_cmd_ready_and_o (req_cmd_ready_and_o),
        .io_cmd_o            (io_cmd_o),
        .io_cmd_v_o          (io_cmd_v_o),
        .io_cmd_ready_and_i  (io_cmd_ready_and_i),
        .io_resp_i           (io_resp_i),
        .io_resp_v_i         (io_resp_v_i),
        .io_resp_yumi_o      (io_resp_yumi_o),
        .req_resp_o          (req_resp_o),
        .req_resp_v_o        (req_resp_v_o),
        .req_resp_yumi_i     (req_resp_yumi_i)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arbitration: first valid requester at or after the pointer
    function automatic int rr_pick(input int ptr, input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    typedef struct {
        int           owner;
        logic [W-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   m_ptr = 0;

    // Monitor: the queue length is the outstanding count
    initial begin
        int           w;
        bit           issue;
        bit           exp_yumi;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_rv;
        forever begin
            @(negedge clk_i);
            if (!reset_n_i) begin
                check("rst_cmd_v",     W'(io_cmd_v_o), '0);
                check("rst_cmd_ready", W'(req_cmd_ready_and_o), '0);
                check("rst_resp_v",    W'(req_resp_v_o), '0);
                check("rst_resp_yumi", W'(io_resp_yumi_o), '0);
                sb_q.delete();
                m_ptr = 0;
            end else begin
                w     = rr_pick(m_ptr, req_cmd_v_i);
                issue = (sb_q.size() < MAXO) && (w >= 0);
                check("cmd_v", W'(io_cmd_v_o), W'(issue));
                exp_rdy = '0;
                if (issue && io_cmd_ready_and_i) exp_rdy[w] = 1'b1;
                check("cmd_ready", W'(req_cmd_ready_and_o), W'(exp_rdy));
                if (issue) check("cmd_data", io_cmd_o, cur_cmd[w]);

                exp_rv   = '0;
                exp_yumi = 1'b0;
                if (io_resp_v_i && sb_q.size() > 0) begin
                    exp_rv[sb_q[0].owner] = 1'b1;
                    exp_yumi = yumi_en[sb_q[0].owner];
                end
                check("resp_route", W'(req_resp_v_o), W'(exp_rv));
                check("resp_yumi",  W'(io_resp_yumi_o), W'(exp_yumi));
                if (exp_yumi) begin
                    check("resp_data", req_resp_o, sb_q[0].data);
                    void'(sb_q.pop_front());
                end

                if (issue && io_cmd_ready_and_i) begin
                    sb_q.push_back('{owner: w, data: cur_cmd[w] ^ KEY});
                    m_ptr = (w + 1) % N;
                end
            end
        end
    end

    typedef struct {
        int           cyc;
        logic [N-1:0] mask;
        int           pv, pr, prs, py;
        bit           rst;
    } phase_t;

    phase_t ph[12] = '{
        '{3,   2'b00, 0,   0,   0,   0,   1'b1},  // power-on reset
        '{8,   2'b11, 100, 100, 0,   0,   1'b0},  // fill to the cap, 0,1,0,1
        '{12,  2'b00, 0,   100, 100, 100, 1'b0},  // drain
        '{6,   2'b10, 100, 100, 100, 100, 1'b0},  // requester 1 alone
        '{5,   2'b01, 100, 0,   100, 100, 1'b0},  // bridge stalled
        '{4,   2'b01, 100, 100, 100, 100, 1'b0},  // stall released
        '{6,   2'b11, 100, 100, 0,   0,   1'b0},  // refill
        '{2,   2'b11, 100, 100, 0,   0,   1'b1},  // reset with work outstanding
        '{6,   2'b10, 100, 100, 50,  50,  1'b0},  // fresh traffic after reset
        '{600, 2'b11, 60,  70,  50,  60,  1'b0},  // random mix
        '{200, 2'b11, 90,  90,  30,  30,  1'b0},  // mostly at the cap
        '{40,  2'b00, 0,   100, 100, 100, 1'b0}   // final drain
    };

    // Driver: requesters hold valid until accepted; bridge answers in order
    initial begin
        logic [W-1:0] bq[$];
        logic [N-1:0] s_xfer;
        logic         s_fire, s_yumi;
        logic [W-1:0] s_cmd;

        reset_n_i          = 1'b0;
        req_cmd_v_i        = '0;
        cur_cmd            = '0;
        io_cmd_ready_and_i = 1'b0;
        io_resp_v_i        = 1'b0;
        io_resp_i          = '0;
        yumi_en            = '0;

        for (int p = 0; p < 12; p++) begin
            for (int c = 0; c < ph[p].cyc; c++) begin
                @(negedge clk_i);
                s_xfer = req_cmd_v_i & req_cmd_ready_and_o;
                s_fire = io_cmd_v_o & io_cmd_ready_and_i;
                s_cmd  = io_cmd_o;
                s_yumi = io_resp_yumi_o;
                @(posedge clk_i);
                #1;
                if (ph[p].rst) begin
                    reset_n_i   = 1'b0;
                    req_cmd_v_i = '0;
                    io_resp_v_i = 1'b0;
                    bq.delete();
                end else begin
                    reset_n_i = 1'b1;
                    if (s_yumi && bq.size() > 0) begin
                        void'(bq.pop_front());
                        io_resp_v_i = 1'b0;
                    end
                    if (s_fire) bq.push_back(s_cmd ^ KEY);
                    req_cmd_v_i = req_cmd_v_i & ~s_xfer;
                    for (int i = 0; i < N; i++) begin
                        if (!req_cmd_v_i[i] && ph[p].mask[i] && $urandom_range(99) < ph[p].pv) begin
                            req_cmd_v_i[i] = 1'b1;
                            cur_cmd[i]     = {$urandom, $urandom};
                        end
                        yumi_en[i] = ($urandom_range(99) < ph[p].py);
                    end
                    io_cmd_ready_and_i = ($urandom_range(99) < ph[p].pr);
                    if (!io_resp_v_i && bq.size() > 0 && $urandom_range(99) < ph[p].prs) begin
                        io_resp_v_i = 1'b1;
                        io_resp_i   = bq[0];
                    end
                end
            end
        end

        @(negedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
